// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation,
// retiring BITS_PER_CYCLE multiplier bits per clock, with valid/ready handshakes on both sides.
module seq_multiplier #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_param_check
      $error("seq_multiplier: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      acc_reg;
  logic [PW-1:0]      mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               neg_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [PW-1:0]      product_reg;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [PW-1:0]      acc_next;
  logic [PW-1:0]      final_next;
  logic               last_step;
  logic [BITS_PER_CYCLE-1:0][PW-1:0] terms;

  // Magnitudes as WIDTH-bit unsigned: -2^(WIDTH-1) maps exactly to 2^(WIDTH-1).
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One partial product per retired multiplier bit; the multiplicand register
  // is pre-shifted each cycle so these are fixed-offset taps.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    acc_next = acc_reg;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      acc_next = acc_next + terms[i];
    end
  end

  assign final_next = neg_reg ? -acc_next : acc_next;
  assign last_step  = (cnt_reg == CNT_W'(N - 1));
  assign product    = product_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      neg_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            neg_reg    <= a_neg ^ b_neg;
            cnt_reg    <= '0;
          end
        end
        BUSY: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
          mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (last_step) product_reg <= final_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
